// File: rtl/exp_lut_arbiter.sv
// exp_lut_arbiter: round-robin arbiter sharing one pipelined exp LUT among
// NUM_REQ requesters. It tags every issued operand with its requester ID and
// routes each LUT result back to that requester. A hold/drain mode stops new
// grants and lets in-flight results finish so the LUT can be reloaded.
// Optional build macro: EXP_LUT_ARB_RANGE_FLAG_EN adds o_rsp_oor, which is
// set when the issued operand was outside [-1.0, +1.0] in q32.32.
module exp_lut_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LUT_LAT = 2,
  parameter int unsigned DATA_W  = 64
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] i_req_operand,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_lut_operand,
  output logic                      o_lut_valid,
  input  logic [DATA_W-1:0]         i_lut_result,
  output logic [NUM_REQ-1:0]        o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_data,
  input  logic                      i_hold,
  output logic                      o_idle
`ifdef EXP_LUT_ARB_RANGE_FLAG_EN
  ,
  output logic                      o_rsp_oor
`endif
);

  localparam int unsigned IDW = $clog2(NUM_REQ);
  // Stage 0 runs alongside o_lut_valid; the last stage lines up with i_lut_result.
  localparam int unsigned PD  = LUT_LAT + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DRAIN  = 2'd2,
    S_HOLD   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic                run_q, run_d;
  logic [IDW-1:0]      rr_q, rr_d;
  logic [DATA_W-1:0]   lut_op_q, lut_op_d;
  logic                lut_vld_q, lut_vld_d;
  logic [PD-1:0]       tag_vld_q, tag_vld_d;
  logic [IDW-1:0]      tag_id_q [PD];
  logic [IDW-1:0]      tag_id_d [PD];
  logic [NUM_REQ-1:0]  rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic                idle_q, idle_d;

  logic                found_c;
  logic [IDW-1:0]      pick_c;
  logic [DATA_W-1:0]   pick_op_c;
  int unsigned         idx_c;
  logic                grant_en_c;
  logic                xfer_c;
  logic                pipe_busy_c;

`ifdef EXP_LUT_ARB_RANGE_FLAG_EN
  localparam logic signed [DATA_W-1:0] POS_ONE = DATA_W'(64'h0000_0001_0000_0000);
  localparam logic signed [DATA_W-1:0] NEG_ONE = -POS_ONE;
  logic [PD-1:0]       tag_oor_q, tag_oor_d;
  logic                rsp_oor_q, rsp_oor_d;
  logic                pick_oor_c;
`endif

  assign pipe_busy_c = |tag_vld_q;

  // Round-robin search starting at the pointer; captures the winner's operand.
  always_comb begin
    found_c   = 1'b0;
    pick_c    = '0;
    pick_op_c = '0;
    idx_c     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx_c = (32'(rr_q) + i) % NUM_REQ;
      if (!found_c && i_req_valid[idx_c]) begin
        found_c   = 1'b1;
        pick_c    = IDW'(idx_c);
        pick_op_c = i_req_operand[idx_c*DATA_W +: DATA_W];
      end
    end
  end

  // FSM state register, plus a flag that holds off grants in the first cycle out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (i_hold)                 state_d = S_HOLD;
        else if (|i_req_valid)      state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (i_hold)                               state_d = S_DRAIN;
        else if (!(|i_req_valid) && !pipe_busy_c) state_d = S_IDLE;
      end
      S_DRAIN: begin
        if (!pipe_busy_c)           state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!i_hold)                state_d = S_IDLE;
      end
      default:                      state_d = S_IDLE;
    endcase
  end

  // FSM outputs: grants only in IDLE/ACTIVE, and never while i_hold is high.
  always_comb begin
    grant_en_c  = run_q && !i_hold && ((state_q == S_IDLE) || (state_q == S_ACTIVE));
    xfer_c      = grant_en_c && found_c;
    o_req_ready = '0;
    if (xfer_c) o_req_ready[pick_c] = 1'b1;
  end

`ifdef EXP_LUT_ARB_RANGE_FLAG_EN
  // Out-of-range classification of the granted operand (signed q32.32).
  always_comb begin
    pick_oor_c = ($signed(pick_op_c) > POS_ONE) || ($signed(pick_op_c) < NEG_ONE);
  end
`endif

  // Datapath next-state: pointer, issue register, tag pipeline, response, idle.
  always_comb begin
    rr_d       = rr_q;
    lut_vld_d  = xfer_c;
    lut_op_d   = xfer_c ? pick_op_c : lut_op_q;
    if (xfer_c) rr_d = (pick_c == IDW'(NUM_REQ - 1)) ? '0 : pick_c + 1'b1;

    tag_vld_d   = {tag_vld_q[PD-2:0], xfer_c};
    tag_id_d[0] = pick_c;
    for (int unsigned i = 1; i < PD; i++) tag_id_d[i] = tag_id_q[i-1];

    rsp_vld_d  = '0;
    rsp_data_d = rsp_data_q;
    if (tag_vld_q[PD-1]) begin
      rsp_vld_d[tag_id_q[PD-1]] = 1'b1;
      rsp_data_d                = i_lut_result;
    end

    idle_d = ((state_d == S_IDLE) || (state_d == S_HOLD)) && (tag_vld_d == '0);
  end

`ifdef EXP_LUT_ARB_RANGE_FLAG_EN
  // Range flag rides the tag pipeline and lands with the response.
  always_comb begin
    tag_oor_d = {tag_oor_q[PD-2:0], pick_oor_c};
    rsp_oor_d = tag_vld_q[PD-1] ? tag_oor_q[PD-1] : 1'b0;
  end

  // Range flag registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tag_oor_q <= '0;
      rsp_oor_q <= 1'b0;
    end else begin
      tag_oor_q <= tag_oor_d;
      rsp_oor_q <= rsp_oor_d;
    end
  end

  assign o_rsp_oor = rsp_oor_q;
`endif

  // Datapath registers; reset drops anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rr_q       <= '0;
      lut_op_q   <= '0;
      lut_vld_q  <= 1'b0;
      tag_vld_q  <= '0;
      for (int unsigned i = 0; i < PD; i++) tag_id_q[i] <= '0;
      rsp_vld_q  <= '0;
      rsp_data_q <= '0;
      idle_q     <= 1'b1;
    end else begin
      rr_q       <= rr_d;
      lut_op_q   <= lut_op_d;
      lut_vld_q  <= lut_vld_d;
      tag_vld_q  <= tag_vld_d;
      for (int unsigned i = 0; i < PD; i++) tag_id_q[i] <= tag_id_d[i];
      rsp_vld_q  <= rsp_vld_d;
      rsp_data_q <= rsp_data_d;
      idle_q     <= idle_d;
    end
  end

  assign o_lut_operand = lut_op_q;
  assign o_lut_valid   = lut_vld_q;
  assign o_rsp_valid   = rsp_vld_q;
  assign o_rsp_data    = rsp_data_q;
  assign o_idle        = idle_q;

endmodule
